// File: rtl/morse_receiver.sv
// morse_receiver: turns a hand-keyed Morse level into the 20-bit
// left-aligned mark/space code word used by the LED blinker.
//
// Ports:
//   blinker_clk  - clock, one Morse time unit per period
//   i_rst        - asynchronous active-high reset
//   i_key        - raw key level (1 = mark), asynchronous to the clock
//   o_morse_code - last decoded character, MSB first, zero-filled
//   o_valid      - one-cycle pulse, o_morse_code/o_err updated
//   o_word       - one-cycle pulse, word gap completed
//   o_err        - last character overflowed the 20-bit word
//   o_busy       - receiver is inside a character or word
module morse_receiver #(
   parameter int DASH_MIN   = 2,
   parameter int LETTER_GAP = 3,
   parameter int WORD_GAP   = 7
) (
   input  logic        blinker_clk,
   input  logic        i_rst,
   input  logic        i_key,
   output logic [19:0] o_morse_code,
   output logic        o_valid,
   output logic        o_word,
   output logic        o_err,
   output logic        o_busy
);

   localparam int CW = $clog2(WORD_GAP + 1);

   typedef enum logic [1:0] {
      IDLE,
      MARK,
      SPACE
   } state_t;

   state_t        state;
   logic          sync1;
   logic          k;
   logic [CW-1:0] mark_cnt;
   logic [CW-1:0] space_cnt;
   logic [19:0]   code_buf;
   logic [4:0]    ptr;
   logic          ovf;

   logic          is_dash;
   logic [19:0]   elem_pat;
   logic [2:0]    elem_len;
   logic [5:0]    fill;
   logic          fits;
   logic [19:0]   buf_app;
   logic [4:0]    ptr_app;
   logic [CW-1:0] space_nxt;
   logic          emit;

   // Two-flop synchronizer for the asynchronous key.
   always_ff @(posedge blinker_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1 <= 1'b0;
         k     <= 1'b0;
      end else begin
         sync1 <= i_key;
         k     <= sync1;
      end
   end

   // Element being closed by the current mark, pre-shifted to the
   // fill pointer. An element that would spill past bit 0 is dropped.
   always_comb begin
      is_dash  = (mark_cnt >= CW'(DASH_MIN));
      elem_pat = is_dash ? 20'hE0000 : 20'h80000;
      elem_len = is_dash ? 3'd4 : 3'd2;
      fill     = {1'b0, ptr} + {3'b000, elem_len};
      fits     = (fill <= 6'd20);
      buf_app  = fits ? (code_buf | (elem_pat >> ptr)) : code_buf;
      ptr_app  = fits ? fill[4:0] : ptr;
   end

   // Space count after this cycle's low sample, saturating.
   always_comb begin
      space_nxt = space_cnt;
      if (space_cnt != CW'(WORD_GAP))
         space_nxt = space_cnt + CW'(1);
      emit = (space_nxt == CW'(LETTER_GAP)) && ((ptr != 5'd0) || ovf);
   end

   always_ff @(posedge blinker_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         mark_cnt     <= '0;
         space_cnt    <= '0;
         code_buf     <= '0;
         ptr          <= '0;
         ovf          <= 1'b0;
         o_morse_code <= '0;
         o_valid      <= 1'b0;
         o_word       <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         o_word  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (k) begin
                  state    <= MARK;
                  mark_cnt <= CW'(1);
               end
            end
            MARK: begin
               if (k) begin
                  if (mark_cnt != CW'(WORD_GAP))
                     mark_cnt <= mark_cnt + CW'(1);
               end else begin
                  code_buf  <= buf_app;
                  ptr       <= ptr_app;
                  ovf       <= ovf | ~fits;
                  space_cnt <= CW'(1);
                  state     <= SPACE;
               end
            end
            SPACE: begin
               if (k) begin
                  // Buffer is kept for an intra-character gap and is
                  // already empty once the letter gap has emitted.
                  state    <= MARK;
                  mark_cnt <= CW'(1);
               end else begin
                  space_cnt <= space_nxt;
                  if (emit) begin
                     o_morse_code <= code_buf;
                     o_err        <= ovf;
                     o_valid      <= 1'b1;
                     code_buf     <= '0;
                     ptr          <= '0;
                     ovf          <= 1'b0;
                  end
                  if (space_nxt == CW'(WORD_GAP)) begin
                     o_word <= 1'b1;
                     state  <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_morse_receiver.sv
// tb_morse_receiver: directed table of keyed characters plus
// hand-written sequences for back-to-back letters and reset.
module tb_morse_receiver;

   logic        blinker_clk = 1'b0;
   logic        i_rst;
   logic        i_key;
   logic [19:0] o_morse_code;
   logic        o_valid;
   logic        o_word;
   logic        o_err;
   logic        o_busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int vcyc = 0;
   int wcyc = 0;
   logic [19:0] code_q[$];
   logic        err_q[$];
   int          ev_q[$];

   morse_receiver dut (
      .blinker_clk (blinker_clk),
      .i_rst       (i_rst),
      .i_key       (i_key),
      .o_morse_code(o_morse_code),
      .o_valid     (o_valid),
      .o_word      (o_word),
      .o_err       (o_err),
      .o_busy      (o_busy)
   );

   always #5 blinker_clk = ~blinker_clk;

   // Event log: 1 = o_valid pulse, 2 = o_word pulse.
   always @(posedge blinker_clk) begin
      #1;
      cyc = cyc + 1;
      if (o_valid) begin
         code_q.push_back(o_morse_code);
         err_q.push_back(o_err);
         ev_q.push_back(1);
         vcyc = cyc;
      end
      if (o_word) begin
         ev_q.push_back(2);
         wcyc = cyc;
      end
   end

   typedef struct {
      string       name;
      logic [63:0] pat;
      int          len;
      logic [19:0] code;
      logic        err;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_log();
      code_q.delete();
      err_q.delete();
      ev_q.delete();
      vcyc = 0;
      wcyc = 0;
   endtask

   // Key levels MSB-first, one unit each, then `tail` low units.
   task automatic drive(input logic [63:0] p, input int n,
                        input int tail);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge blinker_clk);
         i_key = p[i];
      end
      for (int i = 0; i < tail; i++) begin
         @(negedge blinker_clk);
         i_key = 1'b0;
      end
   endtask

   function automatic int word_count();
      int n = 0;
      foreach (ev_q[i]) if (ev_q[i] == 2) n++;
      return n;
   endfunction

   initial begin
      logic [19:0] c0;
      logic        e0;
      logic [5:0]  seq;

      vecs[0] = '{"A",        64'b10111, 5, 20'hB8000, 1'b0};
      vecs[1] = '{"E",        64'b1,     1, 20'h80000, 1'b0};
      vecs[2] = '{"zero",
                  64'b1110111011101110111, 19, 20'hEEEEE, 1'b0};
      vecs[3] = '{"six_dash",
                  64'b11101110111011101110111, 23, 20'hEEEEE, 1'b1};
      vecs[4] = '{"E_after_ovf", 64'b1, 1, 20'h80000, 1'b0};
      vecs[5] = '{"mark2",    64'b11,    2, 20'hE0000, 1'b0};
      vecs[6] = '{"mark9",    64'h1FF,   9, 20'hE0000, 1'b0};
      vecs[7] = '{"space2",   64'b1001,  4, 20'hA0000, 1'b0};

      i_rst = 1'b1;
      i_key = 1'b0;
      repeat (3) @(negedge blinker_clk);
      chk("reset_outs",
          {8'd0, o_morse_code, o_valid, o_word, o_err, o_busy}, 32'd0);
      i_rst = 1'b0;
      repeat (2) @(negedge blinker_clk);

      for (int v = 0; v < 8; v++) begin
         clear_log();
         drive(vecs[v].pat, vecs[v].len, 14);
         c0 = (code_q.size() > 0) ? code_q[0] : 20'hxxxxx;
         e0 = (err_q.size() > 0) ? err_q[0] : 1'bx;
         chk({vecs[v].name, "_nvalid"}, code_q.size(), 1);
         chk({vecs[v].name, "_code"}, {12'd0, c0},
             {12'd0, vecs[v].code});
         chk({vecs[v].name, "_err"}, {31'd0, e0},
             {31'd0, vecs[v].err});
         chk({vecs[v].name, "_nword"}, word_count(), 1);
         chk({vecs[v].name, "_word_delay"}, wcyc - vcyc, 4);
         chk({vecs[v].name, "_busy_end"}, {31'd0, o_busy}, 0);
      end

      // 'E', exactly a letter gap, then 'T'.
      clear_log();
      drive(64'b1000111, 7, 14);
      chk("b2b_nevents", ev_q.size(), 3);
      seq = '0;
      for (int i = 0; i < ev_q.size() && i < 3; i++)
         seq = {seq[3:0], 2'(ev_q[i])};
      chk("b2b_order", {26'd0, seq}, {26'd0, 6'b010110});
      c0 = (code_q.size() > 0) ? code_q[0] : 20'hxxxxx;
      chk("b2b_code0", {12'd0, c0}, 32'h80000);
      c0 = (code_q.size() > 1) ? code_q[1] : 20'hxxxxx;
      chk("b2b_code1", {12'd0, c0}, 32'hE0000);

      // Reset during the dash of 'A'.
      clear_log();
      drive(64'b1011, 4, 0);
      @(negedge blinker_clk);
      #2 i_rst = 1'b1;
      #1;
      chk("rst_mid_outs",
          {8'd0, o_morse_code, o_valid, o_word, o_err, o_busy}, 32'd0);
      repeat (2) @(negedge blinker_clk);
      i_key = 1'b0;
      chk("rst_mid_nopulse", ev_q.size(), 0);
      i_rst = 1'b0;
      repeat (3) @(negedge blinker_clk);
      chk("rst_mid_idle", {31'd0, o_busy}, 0);
      clear_log();
      drive(64'b111, 3, 14);
      c0 = (code_q.size() > 0) ? code_q[0] : 20'hxxxxx;
      e0 = (err_q.size() > 0) ? err_q[0] : 1'bx;
      chk("post_rst_nvalid", code_q.size(), 1);
      chk("post_rst_code", {12'd0, c0}, 32'hE0000);
      chk("post_rst_err", {31'd0, e0}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
